duck_motion: RTL and testbench

Per-duck flight controller for the Duck Hunt VGA datapath. It consumes the 32-bit pseudo-random word from the upstream `random` generator to pick a spawn position, initial heading and mid-flight direction changes. It then advances the duck's sprite coordinates once per video frame through the fly, hit, fall and escape phases. Coordinates and state feed the sprite/colour mapper and the score/round logic downstream.

---
 rtl/duck_motion.sv | 217 +++++++++++++++++++++
 tb/tb_duck_motion.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/duck_motion.sv
// Per-duck flight controller: spawn, fly/bounce, hit pause, fall and escape, advanced once per frame.
// Optional build macro DUCK_ZIGZAG_EN enables random mid-flight x heading flips.
module duck_motion #(
    parameter int unsigned X_MAX        = 608,
    parameter int unsigned Y_MIN        = 0,
    parameter int unsigned Y_FLOOR      = 368,
    parameter int unsigned STEP         = 2,
    parameter int unsigned FALL_STEP    = 4,
    parameter int unsigned FLY_FRAMES   = 512,
    parameter int unsigned PAUSE_FRAMES = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [31:0] rand_data,
    input  logic        start,
    input  logic        hit,
    output logic [9:0]  duck_x,
    output logic [9:0]  duck_y,
    output logic        dir_right,
    output logic        dir_up,
    output logic        duck_active,
    output logic [2:0]  state,
    output logic        fallen,
    output logic        escaped
);

    localparam int unsigned CNT_MAX = (FLY_FRAMES > PAUSE_FRAMES) ? FLY_FRAMES : PAUSE_FRAMES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned AW      = 11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLY    = 3'd1,
        S_HIT    = 3'd2,
        S_FALL   = 3'd3,
        S_ESCAPE = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e          state_q;
    logic [9:0]      duck_x_q;
    logic [9:0]      duck_y_q;
    logic            dir_right_q;
    logic            dir_up_q;
    logic            duck_active_q;
    logic            fallen_q;
    logic            escaped_q;
    logic [CW-1:0]   cnt_q;

    logic            zig_c;
    logic            dir_r_eff_c;
    logic [AW-1:0]   x_up_c;
    logic [AW-1:0]   x_dn_c;
    logic [AW-1:0]   y_up_c;
    logic [AW-1:0]   y_dn_c;
    logic [AW-1:0]   y_fall_c;
    logic [9:0]      x_nxt_c;
    logic [9:0]      y_nxt_c;
    logic            dir_r_nxt_c;
    logic            dir_u_nxt_c;
    logic [9:0]      spawn_x_c;
    logic [CW-1:0]   cnt_inc_c;
    logic            unused_c;

`ifdef DUCK_ZIGZAG_EN
    assign zig_c    = (rand_data[15:11] == 5'd0);
    assign unused_c = ^rand_data[31:16];
`else
    assign zig_c    = 1'b0;
    assign unused_c = ^rand_data[31:11];
`endif

    assign dir_r_eff_c = dir_right_q ^ zig_c;
    assign x_up_c      = {1'b0, duck_x_q} + AW'(STEP);
    assign x_dn_c      = {1'b0, duck_x_q} - AW'(STEP);
    assign y_up_c      = {1'b0, duck_y_q} - AW'(STEP);
    assign y_dn_c      = {1'b0, duck_y_q} + AW'(STEP);
    assign y_fall_c    = {1'b0, duck_y_q} + AW'(FALL_STEP);
    assign spawn_x_c   = rand_data[9:0] % 10'(X_MAX + 1);
    assign cnt_inc_c   = cnt_q + CW'(1);

    // Next flight position with edge clamp and heading inversion on overshoot.
    always_comb begin
        x_nxt_c     = duck_x_q;
        y_nxt_c     = duck_y_q;
        dir_r_nxt_c = dir_r_eff_c;
        dir_u_nxt_c = dir_up_q;
        if (dir_r_eff_c) begin
            if (x_up_c > AW'(X_MAX)) begin
                x_nxt_c     = 10'(X_MAX);
                dir_r_nxt_c = 1'b0;
            end else begin
                x_nxt_c = x_up_c[9:0];
            end
        end else begin
            if ({1'b0, duck_x_q} < AW'(STEP)) begin
                x_nxt_c     = 10'd0;
                dir_r_nxt_c = 1'b1;
            end else begin
                x_nxt_c = x_dn_c[9:0];
            end
        end
        if (dir_up_q) begin
            if ({1'b0, duck_y_q} < AW'(Y_MIN + STEP)) begin
                y_nxt_c     = 10'(Y_MIN);
                dir_u_nxt_c = 1'b0;
            end else begin
                y_nxt_c = y_up_c[9:0];
            end
        end else begin
            if (y_dn_c > AW'(Y_FLOOR)) begin
                y_nxt_c     = 10'(Y_FLOOR);
                dir_u_nxt_c = 1'b1;
            end else begin
                y_nxt_c = y_dn_c[9:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            duck_x_q      <= 10'd0;
            duck_y_q      <= 10'(Y_FLOOR);
            dir_right_q   <= 1'b0;
            dir_up_q      <= 1'b1;
            duck_active_q <= 1'b0;
            fallen_q      <= 1'b0;
            escaped_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            fallen_q  <= 1'b0;
            escaped_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        duck_x_q      <= spawn_x_c;
                        duck_y_q      <= 10'(Y_FLOOR);
                        dir_right_q   <= rand_data[10];
                        dir_up_q      <= 1'b1;
                        cnt_q         <= '0;
                        duck_active_q <= 1'b1;
                        state_q       <= S_FLY;
                    end
                end
                S_FLY: begin
                    // A hit beats both the move and the timeout on the same cycle.
                    if (hit) begin
                        cnt_q   <= '0;
                        state_q <= S_HIT;
                    end else if (frame_tick) begin
                        duck_x_q    <= x_nxt_c;
                        duck_y_q    <= y_nxt_c;
                        dir_right_q <= dir_r_nxt_c;
                        cnt_q       <= cnt_inc_c;
                        if (cnt_inc_c == CW'(FLY_FRAMES)) begin
                            dir_up_q <= 1'b1;
                            state_q  <= S_ESCAPE;
                        end else begin
                            dir_up_q <= dir_u_nxt_c;
                        end
                    end
                end
                S_HIT: begin
                    if (frame_tick) begin
                        cnt_q <= cnt_inc_c;
                        if (cnt_inc_c == CW'(PAUSE_FRAMES)) begin
                            state_q <= S_FALL;
                        end
                    end
                end
                S_FALL: begin
                    if (frame_tick) begin
                        if (y_fall_c >= AW'(Y_FLOOR)) begin
                            duck_y_q      <= 10'(Y_FLOOR);
                            fallen_q      <= 1'b1;
                            duck_active_q <= 1'b0;
                            state_q       <= S_DONE;
                        end else begin
                            duck_y_q <= y_fall_c[9:0];
                        end
                    end
                end
                S_ESCAPE: begin
                    if (frame_tick) begin
                        if ({1'b0, duck_y_q} <= AW'(STEP)) begin
                            duck_y_q      <= 10'd0;
                            escaped_q     <= 1'b1;
                            duck_active_q <= 1'b0;
                            state_q       <= S_DONE;
                        end else begin
                            duck_y_q <= y_up_c[9:0];
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    duck_active_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign duck_x      = duck_x_q;
    assign duck_y      = duck_y_q;
    assign dir_right   = dir_right_q;
    assign dir_up      = dir_up_q;
    assign duck_active = duck_active_q;
    assign state       = state_q;
    assign fallen      = fallen_q;
    assign escaped     = escaped_q;

endmodule

// File: tb/tb_duck_motion.sv
// Directed bench for duck_motion: reset, spawn, bounces, hit/fall, escape and zigzag behaviour.
module tb_duck_motion;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [31:0] rand_data;
    logic        start;
    logic        hit;
    logic [9:0]  duck_x;
    logic [9:0]  duck_y;
    logic        dir_right;
    logic        dir_up;
    logic        duck_active;
    logic [2:0]  state;
    logic        fallen;
    logic        escaped;

    int ntests = 0;
    int nfail  = 0;

    duck_motion dut (
        .Clk         (clk),
        .Reset       (rst),
        .frame_tick  (frame_tick),
        .rand_data   (rand_data),
        .start       (start),
        .hit         (hit),
        .duck_x      (duck_x),
        .duck_y      (duck_y),
        .dir_right   (dir_right),
        .dir_up      (dir_up),
        .duck_active (duck_active),
        .state       (state),
        .fallen      (fallen),
        .escaped     (escaped)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        rand_data  = 32'h0;
        start      = 1'b0;
        hit        = 1'b0;
        cyc();
        cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_x", 32'(duck_x), 32'd0);
        chk("rst_y", 32'(duck_y), 32'd368);
        chk("rst_dir_right", 32'(dir_right), 32'd0);
        chk("rst_dir_up", 32'(dir_up), 32'd1);
        chk("rst_active", 32'(duck_active), 32'd0);
        chk("rst_pulses", 32'({fallen, escaped}), 32'd0);
        rst = 1'b0;
        cyc();
        chk("idle_hold", 32'(state), 32'd0);

        // Spawn: 1023 mod 609 = 414
        rand_data = 32'h0000_07FF;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("spawn_x", 32'(duck_x), 32'd414);
        chk("spawn_y", 32'(duck_y), 32'd368);
        chk("spawn_dir_right", 32'(dir_right), 32'd1);
        chk("spawn_state", 32'(state), 32'd1);
        chk("spawn_active", 32'(duck_active), 32'd1);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_x", 32'(duck_x), 32'd0);
        chk("midrst_active", 32'(duck_active), 32'd0);

        // Right-edge bounce from x=607
        rand_data = 32'h0000_0E5F;
        start = 1'b1;
        cyc();
        start = 1'b0;
        rand_data = 32'h0000_F800;
        chk("b_spawn_x", 32'(duck_x), 32'd607);
        ticks(1);
        chk("b1_x", 32'(duck_x), 32'd608);
        chk("b1_dir_right", 32'(dir_right), 32'd0);
        chk("b1_y", 32'(duck_y), 32'd366);
        ticks(1);
        chk("b2_x", 32'(duck_x), 32'd606);
        chk("b2_y", 32'(duck_y), 32'd364);

        // Climb to y=100 then shoot
        ticks(132);
        chk("pre_hit_y", 32'(duck_y), 32'd100);
        chk("pre_hit_x", 32'(duck_x), 32'd342);
        hit = 1'b1;
        frame_tick = 1'b1;
        cyc();
        hit = 1'b0;
        frame_tick = 1'b0;
        chk("hit_state", 32'(state), 32'd2);
        chk("hit_x", 32'(duck_x), 32'd342);
        chk("hit_y", 32'(duck_y), 32'd100);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("hit_start_ignored", 32'(state), 32'd2);
        ticks(29);
        chk("pause29_state", 32'(state), 32'd2);
        ticks(1);
        chk("pause30_state", 32'(state), 32'd3);
        chk("pause30_y", 32'(duck_y), 32'd100);
        ticks(1);
        chk("fall1_y", 32'(duck_y), 32'd104);
        hit = 1'b1;
        ticks(65);
        hit = 1'b0;
        chk("fall66_y", 32'(duck_y), 32'd364);
        chk("fall66_state", 32'(state), 32'd3);
        chk("fall66_fallen", 32'(fallen), 32'd0);
        ticks(1);
        chk("fall67_y", 32'(duck_y), 32'd368);
        chk("fall67_state", 32'(state), 32'd5);
        chk("fall67_fallen", 32'(fallen), 32'd1);
        chk("fall67_active", 32'(duck_active), 32'd0);
        cyc();
        chk("fall_done_state", 32'(state), 32'd0);
        chk("fall_done_pulse", 32'(fallen), 32'd0);
        chk("fall_done_x", 32'(duck_x), 32'd342);

        // Zigzag tick: x=300 heading right, rand_data[15:11]=0
        rand_data = 32'h0000_052C;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("z_spawn_x", 32'(duck_x), 32'd300);
        rand_data = 32'h0000_0000;
        ticks(1);
`ifdef DUCK_ZIGZAG_EN
        chk("z_x", 32'(duck_x), 32'd298);
        chk("z_dir_right", 32'(dir_right), 32'd0);
`else
        chk("z_x", 32'(duck_x), 32'd302);
        chk("z_dir_right", 32'(dir_right), 32'd1);
`endif
        chk("z_y", 32'(duck_y), 32'd366);
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Escape path from x=0 heading left
        rand_data = 32'h0000_0800;
        start = 1'b1;
        cyc();
        start = 1'b0;
        rand_data = 32'h0000_F800;
        ticks(1);
        chk("e1_x", 32'(duck_x), 32'd0);
        chk("e1_dir_right", 32'(dir_right), 32'd1);
        ticks(183);
        chk("e184_y", 32'(duck_y), 32'd0);
        chk("e184_dir_up", 32'(dir_up), 32'd1);
        ticks(1);
        chk("e185_y", 32'(duck_y), 32'd0);
        chk("e185_dir_up", 32'(dir_up), 32'd0);
        ticks(121);
        chk("e306_x", 32'(duck_x), 32'd608);
        chk("e306_dir_right", 32'(dir_right), 32'd0);
        ticks(64);
        chk("e370_y", 32'(duck_y), 32'd368);
        chk("e370_dir_up", 32'(dir_up), 32'd1);
        ticks(141);
        chk("e511_state", 32'(state), 32'd1);
        ticks(1);
        chk("e512_state", 32'(state), 32'd4);
        chk("e512_y", 32'(duck_y), 32'd84);
        chk("e512_x", 32'(duck_x), 32'd196);
        chk("e512_dir_up", 32'(dir_up), 32'd1);
        ticks(41);
        chk("esc41_y", 32'(duck_y), 32'd2);
        chk("esc41_state", 32'(state), 32'd4);
        chk("esc41_escaped", 32'(escaped), 32'd0);
        ticks(1);
        chk("esc42_y", 32'(duck_y), 32'd0);
        chk("esc42_x", 32'(duck_x), 32'd196);
        chk("esc42_state", 32'(state), 32'd5);
        chk("esc42_escaped", 32'(escaped), 32'd1);
        chk("esc42_fallen", 32'(fallen), 32'd0);
        cyc();
        chk("esc_done_state", 32'(state), 32'd0);
        chk("esc_done_pulse", 32'(escaped), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
